// File: rtl/ppu_pkg.sv
// ppu_pkg: shared definitions for the PPU VRAM fetch controller.
//   - fetch_state_t : fetch/CPU access FSM encoding
//   - NT_BASE, AT_OFFSET, PALETTE_BASE : PPU memory map constants
//   - V_* : bit positions of the loopy v register fields
//   - at_shift() : shift that selects the 2-bit quadrant from an attribute byte
package ppu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_NT   = 3'd1,
    ST_AT   = 3'd2,
    ST_PTL  = 3'd3,
    ST_PTH  = 3'd4,
    ST_CPU  = 3'd5
  } fetch_state_t;

  localparam logic [14:0] NT_BASE      = 15'h2000;
  localparam logic [14:0] AT_OFFSET    = 15'h03C0;
  localparam logic [13:0] PALETTE_BASE = 14'h3F00;

  // loopy v = {fine_y[2:0], nt[1:0], coarse_y[4:0], coarse_x[4:0]}
  localparam int V_COARSE_X_LSB = 0;
  localparam int V_COARSE_Y_LSB = 5;
  localparam int V_NT_LSB       = 10;
  localparam int V_FINE_Y_LSB   = 12;

  // Each attribute byte covers a 4x4 tile area split into 2x2 quadrants.
  // coarse_y[1] picks the top/bottom quadrant pair (4 bits apart) and
  // coarse_x[1] picks the left/right quadrant (2 bits apart).
  function automatic logic [2:0] at_shift(input logic [14:0] v);
    return {v[V_COARSE_Y_LSB + 1], v[V_COARSE_X_LSB + 1], 1'b0};
  endfunction

endpackage

// File: rtl/ppu_vram_addr_gen.sv
// ppu_vram_addr_gen: combinational address generation for one background tile.
// Ports:
//   v         in  15  loopy v register (latched for the running fetch)
//   nt_byte   in   8  tile index fetched from the nametable
//   bg_pt_sel in   1  background pattern table select
//   at_byte   in   8  raw attribute byte (memory read data)
//   nt_addr   out 15  nametable byte address
//   at_addr   out 15  attribute byte address
//   ptl_addr  out 15  pattern low plane address
//   pth_addr  out 15  pattern high plane address
//   at_bits   out  2  palette attribute selected from at_byte
module ppu_vram_addr_gen
  import ppu_pkg::*;
(
  input  logic [14:0] v,
  input  logic [7:0]  nt_byte,
  input  logic        bg_pt_sel,
  input  logic [7:0]  at_byte,
  output logic [14:0] nt_addr,
  output logic [14:0] at_addr,
  output logic [14:0] ptl_addr,
  output logic [14:0] pth_addr,
  output logic [1:0]  at_bits
);

  logic [1:0] nt_sel;
  logic [2:0] fine_y;
  logic [7:0] at_shifted;

  assign nt_sel = v[V_NT_LSB +: 2];
  assign fine_y = v[V_FINE_Y_LSB +: 3];

  assign nt_addr = NT_BASE | {3'b000, v[11:0]};

  // Attribute table: one byte per 4x4 tile block, 8 blocks per row.
  // Row = coarse_y[4:2], column = coarse_x[4:2].
  assign at_addr = NT_BASE | AT_OFFSET
                 | {3'b000, nt_sel, 10'b00_0000_0000}
                 | {9'b0_0000_0000, v[V_COARSE_Y_LSB + 2 +: 3], 3'b000}
                 | {12'b0000_0000_0000, v[V_COARSE_X_LSB + 2 +: 3]};

  // 16 bytes per tile; the high plane sits 8 bytes above the low plane.
  assign ptl_addr = {2'b00, bg_pt_sel, nt_byte, 1'b0, fine_y};
  assign pth_addr = {2'b00, bg_pt_sel, nt_byte, 1'b1, fine_y};

  assign at_shifted = at_byte >> at_shift(v);
  assign at_bits    = at_shifted[1:0];

endmodule

// File: rtl/ppu_vram_fetch_ctrl.sv
// ppu_vram_fetch_ctrl: PPU-side initiator on the PPU memory slave port.
// Runs the background tile fetch (NT, AT, PTL, PTH) and interleaves single
// CPU ($2007) VRAM accesses. Every access occupies ACC_CYCLES clocks with a
// stable address; read data is captured on the last clock of the access.
// Build option: PPU_RDBUF_EN enables the PPUDATA read buffer (reads below
// the palette return the previously fetched byte).
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   fetch_start, v_addr,       tile fetch request and its parameters
//   bg_pt_sel
//   cpu_acc_req, cpu_acc_we,   CPU access request and its parameters
//   cpu_acc_addr, cpu_acc_wdata
//   cpu_acc_rdata, cpu_acc_done  CPU access result / completion pulse
//   busy                       FSM active or a request pending
//   ppu_rd_req, ppu_wr_req,    memory port strobes, address, write data,
//   ppu_addr, ppu_din, ppu_dout read data
//   nt_byte, at_bits, pt_lo,   fetched tile data, updated with tile_valid
//   pt_hi, tile_valid
module ppu_vram_fetch_ctrl
  import ppu_pkg::*;
#(
  parameter int unsigned ACC_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_start,
  input  logic [14:0] v_addr,
  input  logic        bg_pt_sel,
  input  logic        cpu_acc_req,
  input  logic        cpu_acc_we,
  input  logic [13:0] cpu_acc_addr,
  input  logic [7:0]  cpu_acc_wdata,
  output logic [7:0]  cpu_acc_rdata,
  output logic        cpu_acc_done,
  output logic        busy,
  output logic        ppu_rd_req,
  output logic        ppu_wr_req,
  output logic [14:0] ppu_addr,
  output logic [7:0]  ppu_din,
  input  logic [7:0]  ppu_dout,
  output logic [7:0]  nt_byte,
  output logic [1:0]  at_bits,
  output logic [7:0]  pt_lo,
  output logic [7:0]  pt_hi,
  output logic        tile_valid
);

  localparam int unsigned SUB_W = (ACC_CYCLES > 1) ? $clog2(ACC_CYCLES) : 1;
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(ACC_CYCLES - 1);

  fetch_state_t state;
  logic [SUB_W-1:0] sub;
  logic sub_last;

  // Active fetch parameters and partially assembled tile
  logic [14:0] v_cur;
  logic        bg_cur;
  logic [7:0]  nt_cur;
  logic [1:0]  at_cur;
  logic [7:0]  lo_cur;

  // Pending requests (latched in any state)
  logic        fetch_pend;
  logic [14:0] v_pend;
  logic        bg_pend;
  logic        cpu_pend;
  logic        we_pend;
  logic [13:0] addr_pend;
  logic [7:0]  wdata_pend;

  // Active CPU access
  logic        cpu_we;
  logic [13:0] cpu_addr;

`ifdef PPU_RDBUF_EN
  logic [7:0]  rd_buf;
`endif

  // Request selection: a request arriving on this edge overrides a stale pending one
  logic [14:0] v_sel;
  logic        bg_sel;
  logic        we_sel;
  logic [13:0] addr_sel;
  logic [7:0]  wdata_sel;
  logic [14:0] gen_v;

  logic [14:0] nt_addr;
  logic [14:0] at_addr;
  logic [14:0] ptl_addr;
  logic [14:0] pth_addr;
  logic [1:0]  at_sel;

  assign sub_last = (sub == SUB_LAST);
  assign busy     = (state != ST_IDLE) | fetch_pend | cpu_pend;

  // Select between same-cycle requests and pending parameters
  always_comb begin
    v_sel     = fetch_start ? v_addr        : v_pend;
    bg_sel    = fetch_start ? bg_pt_sel     : bg_pend;
    we_sel    = cpu_acc_req ? cpu_acc_we    : we_pend;
    addr_sel  = cpu_acc_req ? cpu_acc_addr  : addr_pend;
    wdata_sel = cpu_acc_req ? cpu_acc_wdata : wdata_pend;
    // The NT address is issued from IDLE, before v is latched
    if (state == ST_IDLE) begin
      gen_v = v_sel;
    end else begin
      gen_v = v_cur;
    end
  end

  ppu_vram_addr_gen u_addr_gen (
    .v         (gen_v),
    .nt_byte   (nt_cur),
    .bg_pt_sel (bg_cur),
    .at_byte   (ppu_dout),
    .nt_addr   (nt_addr),
    .at_addr   (at_addr),
    .ptl_addr  (ptl_addr),
    .pth_addr  (pth_addr),
    .at_bits   (at_sel)
  );

  // Fetch/CPU access FSM with registered memory-port and result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      sub           <= '0;
      v_cur         <= 15'h0000;
      bg_cur        <= 1'b0;
      nt_cur        <= 8'h00;
      at_cur        <= 2'b00;
      lo_cur        <= 8'h00;
      fetch_pend    <= 1'b0;
      v_pend        <= 15'h0000;
      bg_pend       <= 1'b0;
      cpu_pend      <= 1'b0;
      we_pend       <= 1'b0;
      addr_pend     <= 14'h0000;
      wdata_pend    <= 8'h00;
      cpu_we        <= 1'b0;
      cpu_addr      <= 14'h0000;
      cpu_acc_rdata <= 8'h00;
      cpu_acc_done  <= 1'b0;
      ppu_rd_req    <= 1'b0;
      ppu_wr_req    <= 1'b0;
      ppu_addr      <= 15'h0000;
      ppu_din       <= 8'h00;
      nt_byte       <= 8'h00;
      at_bits       <= 2'b00;
      pt_lo         <= 8'h00;
      pt_hi         <= 8'h00;
      tile_valid    <= 1'b0;
`ifdef PPU_RDBUF_EN
      rd_buf        <= 8'h00;
`endif
    end else begin
      tile_valid   <= 1'b0;
      cpu_acc_done <= 1'b0;

      // Capture new requests; consuming them below clears the flag
      if (fetch_start) begin
        fetch_pend <= 1'b1;
        v_pend     <= v_addr;
        bg_pend    <= bg_pt_sel;
      end
      if (cpu_acc_req) begin
        cpu_pend   <= 1'b1;
        we_pend    <= cpu_acc_we;
        addr_pend  <= cpu_acc_addr;
        wdata_pend <= cpu_acc_wdata;
      end

      if (state == ST_IDLE) begin
        sub <= '0;
      end else if (sub_last) begin
        sub <= '0;
      end else begin
        sub <= sub + SUB_W'(1);
      end

      case (state)
        ST_IDLE: begin
          if (fetch_start || fetch_pend) begin
            state      <= ST_NT;
            fetch_pend <= 1'b0;
            v_cur      <= v_sel;
            bg_cur     <= bg_sel;
            ppu_addr   <= nt_addr;
            ppu_rd_req <= 1'b1;
            ppu_wr_req <= 1'b0;
          end else if (cpu_acc_req || cpu_pend) begin
            state      <= ST_CPU;
            cpu_pend   <= 1'b0;
            cpu_we     <= we_sel;
            cpu_addr   <= addr_sel;
            ppu_addr   <= {1'b0, addr_sel};
            ppu_din    <= wdata_sel;
            ppu_rd_req <= ~we_sel;
            ppu_wr_req <= we_sel;
          end else begin
            ppu_rd_req <= 1'b0;
            ppu_wr_req <= 1'b0;
          end
        end
        ST_NT: begin
          if (sub_last) begin
            nt_cur   <= ppu_dout;
            state    <= ST_AT;
            ppu_addr <= at_addr;
          end
        end
        ST_AT: begin
          if (sub_last) begin
            at_cur   <= at_sel;
            state    <= ST_PTL;
            ppu_addr <= ptl_addr;
          end
        end
        ST_PTL: begin
          if (sub_last) begin
            lo_cur   <= ppu_dout;
            state    <= ST_PTH;
            ppu_addr <= pth_addr;
          end
        end
        ST_PTH: begin
          if (sub_last) begin
            nt_byte    <= nt_cur;
            at_bits    <= at_cur;
            pt_lo      <= lo_cur;
            pt_hi      <= ppu_dout;
            tile_valid <= 1'b1;
            // A CPU access waiting behind this fetch goes ahead of any new fetch
            if (cpu_acc_req || cpu_pend) begin
              state      <= ST_CPU;
              cpu_pend   <= 1'b0;
              cpu_we     <= we_sel;
              cpu_addr   <= addr_sel;
              ppu_addr   <= {1'b0, addr_sel};
              ppu_din    <= wdata_sel;
              ppu_rd_req <= ~we_sel;
              ppu_wr_req <= we_sel;
            end else begin
              state      <= ST_IDLE;
              ppu_rd_req <= 1'b0;
            end
          end
        end
        ST_CPU: begin
          // Write strobe lasts one clock; the rest of the slot is padding
          ppu_wr_req <= 1'b0;
          if (sub_last) begin
            state        <= ST_IDLE;
            ppu_rd_req   <= 1'b0;
            cpu_acc_done <= 1'b1;
            if (!cpu_we) begin
`ifdef PPU_RDBUF_EN
              if (cpu_addr < PALETTE_BASE) begin
                cpu_acc_rdata <= rd_buf;
              end else begin
                cpu_acc_rdata <= ppu_dout;
              end
              rd_buf <= ppu_dout;
`else
              cpu_acc_rdata <= ppu_dout;
`endif
            end
          end
        end
        default: begin
          state      <= ST_IDLE;
          ppu_rd_req <= 1'b0;
          ppu_wr_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ppu_vram_fetch_ctrl.sv
module tb_ppu_vram_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_start;
  logic [14:0] v_addr;
  logic        bg_pt_sel;
  logic        cpu_acc_req;
  logic        cpu_acc_we;
  logic [13:0] cpu_acc_addr;
  logic [7:0]  cpu_acc_wdata;
  logic [7:0]  cpu_acc_rdata;
  logic        cpu_acc_done;
  logic        busy;
  logic        ppu_rd_req;
  logic        ppu_wr_req;
  logic [14:0] ppu_addr;
  logic [7:0]  ppu_din;
  logic [7:0]  ppu_dout;
  logic [7:0]  nt_byte;
  logic [1:0]  at_bits;
  logic [7:0]  pt_lo;
  logic [7:0]  pt_hi;
  logic        tile_valid;

  int n_checks = 0;
  int n_errors = 0;

  // Memory slave: 2-clock registered read latency, write on strobe
  logic [7:0]  mem [0:16383];
  logic [7:0]  rd_s1;
  logic        init_en;
  logic        pl_en;
  logic [13:0] pl_addr;
  logic [7:0]  pl_data;

  // Reference model state
  logic [7:0]  ref_mem [0:16383];
  logic [7:0]  ref_buf;

  always #5 clk = ~clk;

  ppu_vram_fetch_ctrl dut (
    .clk(clk), .rst(rst),
    .fetch_start(fetch_start), .v_addr(v_addr), .bg_pt_sel(bg_pt_sel),
    .cpu_acc_req(cpu_acc_req), .cpu_acc_we(cpu_acc_we),
    .cpu_acc_addr(cpu_acc_addr), .cpu_acc_wdata(cpu_acc_wdata),
    .cpu_acc_rdata(cpu_acc_rdata), .cpu_acc_done(cpu_acc_done), .busy(busy),
    .ppu_rd_req(ppu_rd_req), .ppu_wr_req(ppu_wr_req), .ppu_addr(ppu_addr),
    .ppu_din(ppu_din), .ppu_dout(ppu_dout),
    .nt_byte(nt_byte), .at_bits(at_bits), .pt_lo(pt_lo), .pt_hi(pt_hi),
    .tile_valid(tile_valid)
  );

  function automatic logic [7:0] fill_val(input int i);
    return 8'((i * 37 + (i >> 5)) & 255);
  endfunction

  always @(posedge clk) begin
    if (init_en) begin
      for (int i = 0; i < 16384; i++) mem[i] <= fill_val(i);
    end else if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else if (ppu_wr_req) begin
      mem[ppu_addr[13:0]] <= ppu_din;
    end
    rd_s1    <= mem[ppu_addr[13:0]];
    ppu_dout <= rd_s1;
  end

  // Tile contents derived from the memory map rules: {nt, at_bits, lo, hi}
  function automatic logic [25:0] model_tile(input logic [14:0] v, input logic bg);
    int vi, nt_a, at_a, fy, sh, pt_a;
    logic [7:0] nt, at, lo, hi, t;
    vi   = int'(v);
    nt_a = 'h2000 + (vi & 'hFFF);
    at_a = 'h23C0 + ((vi >> 10) & 3) * 'h400 + ((vi >> 7) & 7) * 8 + ((vi >> 2) & 7);
    nt   = ref_mem[14'(nt_a)];
    at   = ref_mem[14'(at_a)];
    fy   = (vi >> 12) & 7;
    pt_a = (bg ? 'h1000 : 0) + int'(nt) * 16 + fy;
    lo   = ref_mem[14'(pt_a)];
    hi   = ref_mem[14'(pt_a + 8)];
    sh   = ((vi >> 6) & 1) * 4 + ((vi >> 1) & 1) * 2;
    t    = at >> sh;
    return {nt, t[1:0], lo, hi};
  endfunction

  // Expected CPU read result; updates the modelled read buffer
  function automatic logic [7:0] model_read(input logic [13:0] a);
    logic [7:0] r;
`ifdef PPU_RDBUF_EN
    r = (a < 14'h3F00) ? ref_buf : ref_mem[a];
    ref_buf = ref_mem[a];
`else
    r = ref_mem[a];
`endif
    return r;
  endfunction

  // Advance one clock and sample #1 later; strobes must never overlap
  task automatic tick();
    @(posedge clk);
    #1;
    n_checks++;
    if ((ppu_rd_req && ppu_wr_req) || ppu_addr[14]) begin
      n_errors++;
      $display("FAIL strobe_excl: rd=%0b wr=%0b addr=%h, required exclusive strobes and addr[14]=0",
               ppu_rd_req, ppu_wr_req, ppu_addr);
    end
  endtask

  task automatic preload(input logic [13:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_en = 1'b0;
    ref_mem[a] = d;
  endtask

  // Issue one CPU access and wait (bounded) for completion
  task automatic cpu_access(input logic we, input logic [13:0] a, input logic [7:0] d,
                            output logic [7:0] rdata, output int lat);
    cpu_acc_req = 1'b1; cpu_acc_we = we; cpu_acc_addr = a; cpu_acc_wdata = d;
    tick();
    cpu_acc_req = 1'b0;
    lat = 1;
    while (!cpu_acc_done && lat < 20) begin
      tick();
      lat++;
    end
    rdata = cpu_acc_rdata;
  endtask

  task automatic test_reset();
    int bad;
    n_checks++;
    if ({cpu_acc_rdata, cpu_acc_done, busy, ppu_rd_req, ppu_wr_req, ppu_addr, ppu_din,
         nt_byte, at_bits, pt_lo, pt_hi, tile_valid} !== 77'd0) begin
      n_errors++;
      $display("FAIL reset_outputs: some output nonzero (busy=%0b addr=%h), required all 0", busy, ppu_addr);
    end
    rst = 1'b0;
    tick();
    fetch_start = 1'b1; v_addr = 15'h1234; bg_pt_sel = 1'b1;
    tick();
    fetch_start = 1'b0;
    cpu_acc_req = 1'b1; cpu_acc_we = 1'b0; cpu_acc_addr = 14'h2100;
    tick();
    cpu_acc_req = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({cpu_acc_rdata, cpu_acc_done, busy, ppu_rd_req, ppu_wr_req, ppu_addr, ppu_din,
         nt_byte, at_bits, pt_lo, pt_hi, tile_valid} !== 77'd0) begin
      n_errors++;
      $display("FAIL reset_midfetch: busy=%0b rd=%0b addr=%h, required all outputs 0", busy, ppu_rd_req, ppu_addr);
    end
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (tile_valid || cpu_acc_done || ppu_rd_req || busy) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_errors++;
      $display("FAIL reset_no_activity: %0d active cycles after reset, required 0", bad);
    end
  endtask

  task automatic test_rdbuf();
    logic [7:0] r;
    int lat;
    logic [7:0] e1, e2;
    preload(14'h2000, 8'h11);
    preload(14'h2001, 8'h22);
`ifdef PPU_RDBUF_EN
    e1 = 8'h00; e2 = 8'h11;
`else
    e1 = 8'h11; e2 = 8'h22;
`endif
    cpu_access(1'b0, 14'h2000, 8'h00, r, lat);
    n_checks++;
    if (r !== e1 || lat != 4) begin
      n_errors++;
      $display("FAIL read_2000: rdata=%h lat=%0d, required %h lat=4", r, lat, e1);
    end
    cpu_access(1'b0, 14'h2001, 8'h00, r, lat);
    n_checks++;
    if (r !== e2 || lat != 4) begin
      n_errors++;
      $display("FAIL read_2001: rdata=%h lat=%0d, required %h lat=4", r, lat, e2);
    end
    ref_buf = 8'h22;
  endtask

  task automatic test_tile_fetch();
    logic [14:0] exp_a [4];
    exp_a[0] = 15'h2C63; exp_a[1] = 15'h2FC0; exp_a[2] = 15'h1241; exp_a[3] = 15'h1249;
    preload(14'h2C63, 8'h24);
    preload(14'h2FC0, 8'hC0);
    preload(14'h1241, 8'hAA);
    preload(14'h1249, 8'h55);
    fetch_start = 1'b1; v_addr = 15'h1C63; bg_pt_sel = 1'b1;
    tick();
    fetch_start = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      n_checks++;
      if (ppu_addr !== exp_a[(c - 1) / 3] || ppu_rd_req !== 1'b1 || tile_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL tile_addr c%0d: addr=%h rd=%0b tv=%0b, required addr=%h rd=1 tv=0",
                 c, ppu_addr, ppu_rd_req, tile_valid, exp_a[(c - 1) / 3]);
      end
      tick();
    end
    n_checks++;
    if (tile_valid !== 1'b1 || nt_byte !== 8'h24 || at_bits !== 2'b11 || pt_lo !== 8'hAA || pt_hi !== 8'h55) begin
      n_errors++;
      $display("FAIL tile_data: tv=%0b nt=%h at=%b lo=%h hi=%h, required tv=1 nt=24 at=11 lo=aa hi=55",
               tile_valid, nt_byte, at_bits, pt_lo, pt_hi);
    end
    tick();
    n_checks++;
    if (tile_valid !== 1'b0 || ppu_rd_req !== 1'b0 || busy !== 1'b0 || nt_byte !== 8'h24) begin
      n_errors++;
      $display("FAIL tile_after: tv=%0b rd=%0b busy=%0b nt=%h, required 0 0 0 nt=24",
               tile_valid, ppu_rd_req, busy, nt_byte);
    end
  endtask

  task automatic test_cpu_write();
    cpu_acc_req = 1'b1; cpu_acc_we = 1'b1; cpu_acc_addr = 14'h2005; cpu_acc_wdata = 8'h7E;
    tick();
    cpu_acc_req = 1'b0;
    n_checks++;
    if (ppu_wr_req !== 1'b1 || ppu_rd_req !== 1'b0 || ppu_addr !== 15'h2005 || ppu_din !== 8'h7E) begin
      n_errors++;
      $display("FAIL wr_strobe: wr=%0b rd=%0b addr=%h din=%h, required wr=1 rd=0 addr=2005 din=7e",
               ppu_wr_req, ppu_rd_req, ppu_addr, ppu_din);
    end
    for (int c = 2; c <= 3; c++) begin
      tick();
      n_checks++;
      if (ppu_wr_req !== 1'b0 || ppu_rd_req !== 1'b0 || cpu_acc_done !== 1'b0) begin
        n_errors++;
        $display("FAIL wr_pad c%0d: wr=%0b rd=%0b done=%0b, required all 0", c, ppu_wr_req, ppu_rd_req, cpu_acc_done);
      end
    end
    tick();
    n_checks++;
    if (cpu_acc_done !== 1'b1) begin
      n_errors++;
      $display("FAIL wr_done: done=%0b at cycle 4, required 1", cpu_acc_done);
    end
    tick();
    n_checks++;
    if (cpu_acc_done !== 1'b0 || mem[14'h2005] !== 8'h7E) begin
      n_errors++;
      $display("FAIL wr_effect: done=%0b mem=%h, required done=0 mem=7e", cpu_acc_done, mem[14'h2005]);
    end
    ref_mem[14'h2005] = 8'h7E;
  endtask

  task automatic test_collision();
    logic [25:0] et;
    int t_cyc, d_cyc, w_cyc;
    logic [25:0] got;
    et = model_tile(15'h0421, 1'b0);
    t_cyc = 0; d_cyc = 0; w_cyc = 0; got = 26'd0;
    fetch_start = 1'b1; v_addr = 15'h0421; bg_pt_sel = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      fetch_start = 1'b0;
      if (c == 2) begin
        cpu_acc_req = 1'b1; cpu_acc_we = 1'b1; cpu_acc_addr = 14'h2456; cpu_acc_wdata = 8'hB7;
      end else begin
        cpu_acc_req = 1'b0;
      end
      if (tile_valid && t_cyc == 0) begin t_cyc = c; got = {nt_byte, at_bits, pt_lo, pt_hi}; end
      if (ppu_wr_req && w_cyc == 0) w_cyc = c;
      if (cpu_acc_done && d_cyc == 0) d_cyc = c;
    end
    ref_mem[14'h2456] = 8'hB7;
    n_checks++;
    if (t_cyc != 13 || got !== et) begin
      n_errors++;
      $display("FAIL coll_tile: cycle=%0d data=%h, required cycle=13 data=%h", t_cyc, got, et);
    end
    n_checks++;
    if (w_cyc != 13 || d_cyc != 16 || mem[14'h2456] !== 8'hB7) begin
      n_errors++;
      $display("FAIL coll_cpu: wr_cycle=%0d done_cycle=%0d mem=%h, required 13 16 b7", w_cyc, d_cyc, mem[14'h2456]);
    end
  endtask

  task automatic test_simultaneous();
    logic [25:0] et;
    logic [7:0]  er;
    logic [25:0] got;
    logic [7:0]  gr;
    int t_cyc, d_cyc, r_cyc;
    preload(14'h3F05, 8'h3C);
    et = model_tile(15'h7ABC, 1'b1);
    er = model_read(14'h3F05);
    t_cyc = 0; d_cyc = 0; r_cyc = 0; got = 26'd0; gr = 8'h00;
    fetch_start = 1'b1; v_addr = 15'h7ABC; bg_pt_sel = 1'b1;
    cpu_acc_req = 1'b1; cpu_acc_we = 1'b0; cpu_acc_addr = 14'h3F05;
    for (int c = 1; c <= 40; c++) begin
      tick();
      fetch_start = 1'b0;
      cpu_acc_req = 1'b0;
      if (c == 1) begin
        n_checks++;
        if (ppu_addr !== 15'h2ABC || ppu_rd_req !== 1'b1) begin
          n_errors++;
          $display("FAIL simul_first: addr=%h rd=%0b, required NT addr 2abc rd=1", ppu_addr, ppu_rd_req);
        end
      end
      if (tile_valid && t_cyc == 0) begin t_cyc = c; got = {nt_byte, at_bits, pt_lo, pt_hi}; end
      if (ppu_rd_req && ppu_addr == 15'h3F05 && r_cyc == 0) r_cyc = c;
      if (cpu_acc_done && d_cyc == 0) begin d_cyc = c; gr = cpu_acc_rdata; end
    end
    n_checks++;
    if (t_cyc != 13 || got !== et) begin
      n_errors++;
      $display("FAIL simul_tile: cycle=%0d data=%h, required cycle=13 data=%h", t_cyc, got, et);
    end
    n_checks++;
    if (r_cyc != 13 || d_cyc != 16 || gr !== er) begin
      n_errors++;
      $display("FAIL simul_cpu: start=%0d done=%0d rdata=%h, required 13 16 %h", r_cyc, d_cyc, gr, er);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      int m, d, t_cyc, d_cyc, t_cnt, d_cnt, exp_done;
      logic [14:0] rv;
      logic rb, we;
      logic [13:0] ca;
      logic [7:0] wd, er, gr;
      logic [25:0] et, got;
      m  = $urandom_range(0, 2);
      d  = (m == 2) ? $urandom_range(0, 11) : 0;
      rv = 15'($urandom);
      rb = 1'($urandom);
      we = 1'($urandom);
      wd = 8'($urandom);
      case ($urandom_range(0, 2))
        0: ca = 14'($urandom_range(0, 'h1FFF));
        1: ca = 14'('h2000 + $urandom_range(0, 'hFFF));
        default: ca = 14'('h3F00 + $urandom_range(0, 31));
      endcase
      et = 26'd0; er = 8'h00;
      if (m != 1) et = model_tile(rv, rb);
      if (m != 0) begin
        if (we) ref_mem[ca] = wd;
        else er = model_read(ca);
      end
      exp_done = (m == 2) ? 16 : 4;
      t_cyc = 0; d_cyc = 0; t_cnt = 0; d_cnt = 0; got = 26'd0; gr = 8'h00;
      fetch_start = (m != 1); v_addr = rv; bg_pt_sel = rb;
      cpu_acc_we = we; cpu_acc_addr = ca; cpu_acc_wdata = wd;
      cpu_acc_req = (m != 0) && (d == 0);
      for (int c = 1; c <= 40; c++) begin
        tick();
        fetch_start = 1'b0;
        cpu_acc_req = (m != 0) && (d == c);
        if (tile_valid) begin t_cnt++; t_cyc = c; got = {nt_byte, at_bits, pt_lo, pt_hi}; end
        if (cpu_acc_done) begin d_cnt++; d_cyc = c; gr = cpu_acc_rdata; end
      end
      n_checks++;
      if (busy !== 1'b0 || t_cnt != ((m != 1) ? 1 : 0) || d_cnt != ((m != 0) ? 1 : 0)) begin
        n_errors++;
        $display("FAIL rnd%0d_events: busy=%0b tiles=%0d dones=%0d mode=%0d", it, busy, t_cnt, d_cnt, m);
      end
      if (m != 1) begin
        n_checks++;
        if (t_cyc != 13 || got !== et) begin
          n_errors++;
          $display("FAIL rnd%0d_tile: v=%h cycle=%0d data=%h, required cycle=13 data=%h", it, rv, t_cyc, got, et);
        end
      end
      if (m != 0) begin
        n_checks++;
        if (d_cyc != exp_done || (!we && gr !== er)) begin
          n_errors++;
          $display("FAIL rnd%0d_cpu: we=%0b addr=%h done=%0d rdata=%h, required done=%0d rdata=%h",
                   it, we, ca, d_cyc, gr, exp_done, er);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) ref_mem[i] = fill_val(i);
    ref_buf = 8'h00;
    rst = 1'b1; fetch_start = 1'b0; v_addr = 15'h0000; bg_pt_sel = 1'b0;
    cpu_acc_req = 1'b0; cpu_acc_we = 1'b0; cpu_acc_addr = 14'h0000; cpu_acc_wdata = 8'h00;
    pl_en = 1'b0; pl_addr = 14'h0000; pl_data = 8'h00;
    init_en = 1'b1;
    tick();
    init_en = 1'b0;
    tick();
    test_reset();
    test_rdbuf();
    test_tile_fetch();
    test_cpu_write();
    test_collision();
    test_simultaneous();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
